sum_pipe_acc: RTL and testbench



---
 rtl/sum_pipe_acc.sv | 130 +++++++++++++
 tb/tb_sum_pipe_acc.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_pipe_acc.sv
// Two-stage pipelined add / subtract / accumulate unit behind a valid/ready handshake.
// Carry (borrow), signed overflow and zero are registered with the result.
module sum_pipe_acc #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    logic             s1_valid_q;
    op_e              s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_cin_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             s1_advance;
    logic [WIDTH-1:0] lhs, rhs;
    logic [WIDTH:0]   raw;

    assign s1_advance = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s1_advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
        end
    end

    // NOTE: operand payload is qualified by s1_valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_op_q  <= op_e'(op);
            s1_a_q   <= a;
            s1_b_q   <= b;
            s1_cin_q <= cin;
        end
    end

    // The accumulator is read here, in S2, so back-to-back acc beats chain naturally.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        lhs     = (s1_op_q == OP_ACC) ? acc_q  : s1_a_q;
        rhs     = (s1_op_q == OP_ACC) ? s1_a_q : s1_b_q;
        raw     = '0;
        sum_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        acc_d   = acc_q;
        case (s1_op_q)
            OP_ADD, OP_ACC: begin
                raw     = {1'b0, lhs} + {1'b0, rhs} + {{WIDTH{1'b0}}, s1_cin_q};
                carry_d = raw[WIDTH];
                ovf_d   = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (raw[WIDTH-1] != lhs[WIDTH-1]);
                sum_d   = (SAT && carry_d) ? '1 : raw[WIDTH-1:0];
            end
            OP_SUB: begin
                raw     = {1'b0, lhs} - {1'b0, rhs} - {{WIDTH{1'b0}}, s1_cin_q};
                carry_d = raw[WIDTH];
                ovf_d   = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (raw[WIDTH-1] != lhs[WIDTH-1]);
                sum_d   = (SAT && carry_d) ? '0 : raw[WIDTH-1:0];
            end
            default: ;
        endcase
        zero_d = (sum_d == '0);
        if (s1_op_q == OP_ACC) begin
            acc_d = sum_d;
        end else if (s1_op_q == OP_CLR) begin
            acc_d = '0;
        end
    end

    // A stalled result (out_valid && !out_ready) keeps every S2 register frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            acc_q       <= '0;
        end else if (s1_advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
                zero_q  <= zero_d;
                acc_q   <= acc_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_sum_pipe_acc.sv
// Bench for sum_pipe_acc: three instances (8-bit wrap, 8-bit saturating, 16-bit wrap) share
// one stimulus stream; results are predicted in order from the arithmetic rules.
module tb_sum_pipe_acc;

    localparam int NB = 10000;

    typedef struct {
        longint sum;
        bit     carry;
        bit     ovf;
        bit     zero;
        longint acc;
    } res_t;

    typedef struct {
        res_t r8;
        res_t r8s;
        res_t r16;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;

    logic        rdy8, rdy8s, rdy16;
    logic        vld8, vld8s, vld16;
    logic [7:0]  sum8, sum8s, acc8, acc8s;
    logic [15:0] sum16, acc16;
    logic        c8, c8s, c16, o8, o8s, o16, z8, z8s, z16;

    beat_t       exp_q[$];
    longint      macc[3];
    int          checks = 0;
    int          errors = 0;
    int          accepted = 0;
    int          retired = 0;

    sum_pipe_acc #(.WIDTH(8), .SAT(1'b0)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .op(op),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(vld8), .out_ready(out_ready),
        .sum(sum8), .carry(c8), .ovf(o8), .zero(z8), .acc(acc8)
    );

    sum_pipe_acc #(.WIDTH(8), .SAT(1'b1)) u_w8s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8s), .op(op),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(vld8s), .out_ready(out_ready),
        .sum(sum8s), .carry(c8s), .ovf(o8s), .zero(z8s), .acc(acc8s)
    );

    sum_pipe_acc #(.WIDTH(16), .SAT(1'b0)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .op(op),
        .a(a), .b(b), .cin(cin), .out_valid(vld16), .out_ready(out_ready),
        .sum(sum16), .carry(c16), .ovf(o16), .zero(z16), .acc(acc16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t e, input logic [63:0] s,
                             input logic c, input logic o, input logic z, input logic [63:0] ac);
        check({tag, "_sum"}, s, e.sum);
        check({tag, "_carry"}, {63'd0, c}, {63'd0, e.carry});
        check({tag, "_ovf"}, {63'd0, o}, {63'd0, e.ovf});
        check({tag, "_zero"}, {63'd0, z}, {63'd0, e.zero});
        check({tag, "_acc"}, ac, e.acc);
    endtask

    // Reference: true signed/unsigned arithmetic on wide integers, then reduced to w bits.
    function automatic res_t model(input int idx, input int w, input bit sat, input logic [1:0] o,
                                   input longint av, input longint bv, input bit c);
        longint m    = (longint'(1) <<< w) - 1;
        longint half = longint'(1) <<< (w - 1);
        longint cl   = longint'(c);
        longint x, y, sx, sy, raw, sres;
        res_t   r;
        av = av & m;
        bv = bv & m;
        x  = (o == 2'b10) ? macc[idx] : av;
        y  = (o == 2'b10) ? av : bv;
        sx = (x >= half) ? x - 2 * half : x;
        sy = (y >= half) ? y - 2 * half : y;
        if (o == 2'b01) begin
            raw     = x - y - cl;
            r.carry = (raw < 0);
            sres    = sx - sy - cl;
        end else begin
            raw     = x + y + cl;
            r.carry = (raw > m);
            sres    = sx + sy + cl;
        end
        r.ovf = (sres >= half) || (sres < -half);
        r.sum = raw & m;
        if (sat && r.carry) r.sum = (o == 2'b01) ? 0 : m;
        if (o == 2'b11) begin
            r.sum   = 0;
            r.carry = 1'b0;
            r.ovf   = 1'b0;
        end
        r.zero = (r.sum == 0);
        if (o == 2'b10 || o == 2'b11) macc[idx] = r.sum;
        r.acc = macc[idx];
        return r;
    endfunction

    // Monitor: handshakes are decided on the next rising edge, so sample mid-cycle.
    always @(negedge clk) begin
        beat_t e;
        beat_t nb;
        if (!rst) begin
            if (vld8) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q[0];
                    check_res("w8", e.r8, {56'd0, sum8}, c8, o8, z8, {56'd0, acc8});
                    check_res("w8sat", e.r8s, {56'd0, sum8s}, c8s, o8s, z8s, {56'd0, acc8s});
                    check_res("w16", e.r16, {48'd0, sum16}, c16, o16, z16, {48'd0, acc16});
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        retired++;
                    end
                end
            end
            if (in_valid && rdy8) begin
                nb.r8  = model(0, 8, 1'b0, op, longint'(a), longint'(b), cin);
                nb.r8s = model(1, 8, 1'b1, op, longint'(a), longint'(b), cin);
                nb.r16 = model(2, 16, 1'b0, op, longint'(a), longint'(b), cin);
                exp_q.push_back(nb);
                accepted++;
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        exp_q.delete();
        macc = '{0, 0, 0};
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", {63'd0, vld8}, 64'd0);
        check("rst_sum", {56'd0, sum8}, 64'd0);
        check("rst_carry", {63'd0, c8}, 64'd0);
        check("rst_ovf", {63'd0, o8}, 64'd0);
        check("rst_zero", {63'd0, z8}, 64'd1);
        check("rst_acc8", {56'd0, acc8}, 64'd0);
        check("rst_acc16", {48'd0, acc16}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, rdy8}, 64'd1);
    endtask

    // Offer one beat from just after an edge; returns just after the edge that took it.
    task automatic send(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input logic c);
        int n = 0;
        op = o;
        a = av;
        b = bv;
        cin = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!rdy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy8) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'h00FF;
            5: return 16'h0080;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int r0;
        int start;
        int cyc;
        do_reset();

        // 0xFF + 0x01: wrap with carry; the saturating instance pins at 0xFF.
        out_ready = 1'b1;
        send(2'b00, 16'h00FF, 16'h0001, 1'b0);
        check("lat_not_yet", {63'd0, vld8}, 64'd0);
        @(posedge clk); #1;
        check("lat_valid", {63'd0, vld8}, 64'd1);
        check("ff1_sum", {56'd0, sum8}, 64'h00);
        check("ff1_carry", {63'd0, c8}, 64'd1);
        check("ff1_zero", {63'd0, z8}, 64'd1);
        check("ff1_ovf", {63'd0, o8}, 64'd0);
        check("ff1_sat_sum", {56'd0, sum8s}, 64'hFF);
        check("ff1_sat_carry", {63'd0, c8s}, 64'd1);

        send(2'b00, 16'h007F, 16'h0001, 1'b0);
        @(posedge clk); #1;
        check("ovf_sum", {56'd0, sum8}, 64'h80);
        check("ovf_flag", {63'd0, o8}, 64'd1);
        check("ovf_carry", {63'd0, c8}, 64'd0);

        send(2'b01, 16'h0000, 16'h0001, 1'b0);
        @(posedge clk); #1;
        check("sub_sum", {56'd0, sum8}, 64'hFF);
        check("sub_borrow", {63'd0, c8}, 64'd1);
        check("sub_ovf", {63'd0, o8}, 64'd0);
        check("sub_sat_sum", {56'd0, sum8s}, 64'h00);

        // Clear, then three back-to-back accumulates of 0x10.
        send(2'b11, 16'h0000, 16'h0000, 1'b0);
        repeat (3) send(2'b10, 16'h0010, 16'h0000, 1'b0);
        check("acc_chain_2nd", {56'd0, sum8}, 64'h20);
        @(posedge clk); #1;
        check("acc_chain_3rd", {56'd0, sum8}, 64'h30);
        check("acc_chain_acc8", {56'd0, acc8}, 64'h30);
        check("acc_chain_acc16", {48'd0, acc16}, 64'h30);
        drain();

        // Backpressure: five adds, consumer stalls four cycles after the first result.
        r0 = retired;
        fork
            begin
                for (int i = 0; i < 5; i++) send(2'b00, pick16(), pick16(), 1'($urandom));
            end
            begin : stall
                int n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                end while (!vld8 && n < 50);
                check("bp_first_out", {63'd0, vld8}, 64'd1);
                out_ready = 1'b0;
                #1;
                check("bp_in_ready_drop", {63'd0, rdy8}, 64'd0);
                repeat (4) begin
                    @(posedge clk); #1;
                    check("bp_hold_ready", {63'd0, rdy8}, 64'd0);
                    check("bp_hold_valid", {63'd0, vld8}, 64'd1);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(retired - r0), 64'd5);

        // Reset with beats in both stages and one more being offered.
        out_ready = 1'b0;
        send(2'b10, 16'h0005, 16'h0000, 1'b0);
        send(2'b00, 16'h0001, 16'h0002, 1'b0);
        check("mid_acc_before", {56'd0, acc8}, 64'h35);
        op = 2'b10;
        a = 16'h0009;
        in_valid = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("mid_no_stale", {63'd0, vld8}, 64'd0);
        end
        check("mid_acc_after", {56'd0, acc8}, 64'd0);

        // Random traffic with random offer and consume rates.
        start = accepted;
        cyc = 0;
        while (accepted - start < NB && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            op        = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a         = pick16();
            b         = pick16();
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_beats", 64'(accepted - start), 64'(NB));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
